// File: rtl/clock_supervisor.sv
// clock_supervisor: qualifies a monitored clock against the reference clock
// and drives the select of a glitch-free clock mux (1 = fallback, 0 = primary).
module clock_supervisor #(
  parameter int STAGES          = 2,
  parameter int WINDOW_CYCLES   = 64,
  parameter int COUNT_WIDTH     = 8,
  parameter int MIN_TOGGLES     = 8,
  parameter int MAX_TOGGLES     = 24,
  parameter int QUALIFY_WINDOWS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       force_fallback,
  input  logic       monitored_toggle,
  input  logic       clear_failures,
  output logic       select,
  output logic       primary_good,
  output logic       switch_event,
  output logic [7:0] failure_count
);

  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int SW = $clog2(QUALIFY_WINDOWS + 1);

  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] TOG_SAT = '1;
  localparam logic [COUNT_WIDTH-1:0] TOG_MIN = COUNT_WIDTH'(MIN_TOGGLES);
  localparam logic [COUNT_WIDTH-1:0] TOG_MAX = COUNT_WIDTH'(MAX_TOGGLES);
  localparam logic [SW-1:0] STREAK_LAST = SW'(QUALIFY_WINDOWS - 1);

  typedef enum logic {
    ST_FALLBACK = 1'b0,
    ST_PRIMARY  = 1'b1
  } state_t;

  logic [STAGES-1:0]      r_sync;
  logic                   r_hist;
  logic [WW-1:0]          r_win;
  logic [COUNT_WIDTH-1:0] r_tog;
  logic [SW-1:0]          r_streak;
  state_t                 r_state;
  logic                   r_select;
  logic                   r_primary_good;
  logic                   r_switch;
  logic [7:0]             r_fail;

  logic                   w_sync_out;
  logic                   w_edge;
  logic                   w_win_end;
  logic [COUNT_WIDTH-1:0] w_tog_next;
  logic                   w_in_range;
  logic                   w_win_good;
  logic                   w_win_bad;
  logic                   w_override;
  logic                   w_loss;

  assign w_sync_out = r_sync[STAGES-1];
  assign w_edge     = w_sync_out ^ r_hist;
  assign w_win_end  = enable && (r_win == WIN_LAST);

  // An edge seen in the window-end cycle still belongs to the ending window.
  assign w_tog_next = (w_edge && (r_tog != TOG_SAT))
                    ? r_tog + COUNT_WIDTH'(1)
                    : r_tog;

  assign w_in_range = (w_tog_next >= TOG_MIN) && (w_tog_next <= TOG_MAX);
  assign w_win_good = w_win_end && w_in_range;
  assign w_win_bad  = w_win_end && !w_in_range;

  // Disable beats force, and both beat any window verdict.
  assign w_override = !enable || force_fallback;
  assign w_loss     = !w_override && (r_state == ST_PRIMARY) && w_win_bad;

  // Resynchronise the async toggle flop, keep one history stage for edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(monitored_toggle);
      r_hist <= w_sync_out;
    end
  end

  // Window position and saturating toggle count, both parked while disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win <= '0;
      r_tog <= '0;
    end else if (!enable) begin
      r_win <= '0;
      r_tog <= '0;
    end else if (w_win_end) begin
      r_win <= '0;
      r_tog <= '0;
    end else begin
      r_win <= r_win + WW'(1);
      r_tog <= w_tog_next;
    end
  end

  // Selection FSM with registered mux select, status and switch pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_FALLBACK;
      r_streak       <= '0;
      r_select       <= 1'b1;
      r_primary_good <= 1'b0;
      r_switch       <= 1'b0;
    end else begin
      r_switch <= 1'b0;
      if (w_override) begin
        r_state        <= ST_FALLBACK;
        r_streak       <= '0;
        r_select       <= 1'b1;
        r_primary_good <= 1'b0;
        if (r_state == ST_PRIMARY) begin
          r_switch <= 1'b1;
        end
      end else begin
        unique case (r_state)
          ST_FALLBACK: begin
            if (w_win_good) begin
              if (r_streak == STREAK_LAST) begin
                r_state        <= ST_PRIMARY;
                r_streak       <= '0;
                r_select       <= 1'b0;
                r_primary_good <= 1'b1;
                r_switch       <= 1'b1;
              end else begin
                r_streak <= r_streak + SW'(1);
              end
            end else if (w_win_bad) begin
              r_streak <= '0;
            end
          end
          ST_PRIMARY: begin
            if (w_win_bad) begin
              r_state        <= ST_FALLBACK;
              r_streak       <= '0;
              r_select       <= 1'b1;
              r_primary_good <= 1'b0;
              r_switch       <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Saturating count of primary losses; an explicit clear always wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fail <= 8'd0;
    end else if (clear_failures) begin
      r_fail <= 8'd0;
    end else if (w_loss && (r_fail != 8'hFF)) begin
      r_fail <= r_fail + 8'd1;
    end
  end

  assign select        = r_select;
  assign primary_good  = r_primary_good;
  assign switch_event  = r_switch;
  assign failure_count = r_fail;

endmodule

// File: tb/tb_clock_supervisor.sv
// tb_clock_supervisor: directed bench for clock_supervisor.
// A small-window second instance exercises failure counter saturation.
module tb_clock_supervisor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       force_fallback = 1'b0;
  logic       monitored_toggle = 1'b0;
  logic       clear_failures = 1'b0;
  logic       select;
  logic       primary_good;
  logic       switch_event;
  logic [7:0] failure_count;

  logic       mon2 = 1'b0;
  logic       clr2 = 1'b0;
  logic       sel2;
  logic       pg2;
  logic       sw2;
  logic [7:0] fail2;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;
  int tcnt   = 0;
  int period = 0;
  int period2 = 0;
  int w0     = 0;

  always #5 clock = ~clock;

  clock_supervisor dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .force_fallback   (force_fallback),
    .monitored_toggle (monitored_toggle),
    .clear_failures   (clear_failures),
    .select           (select),
    .primary_good     (primary_good),
    .switch_event     (switch_event),
    .failure_count    (failure_count)
  );

  clock_supervisor #(
    .WINDOW_CYCLES   (16),
    .MIN_TOGGLES     (2),
    .MAX_TOGGLES     (6),
    .QUALIFY_WINDOWS (1)
  ) dut2 (
    .clock            (clock),
    .reset            (reset),
    .enable           (1'b1),
    .force_fallback   (1'b0),
    .monitored_toggle (mon2),
    .clear_failures   (clr2),
    .select           (sel2),
    .primary_good     (pg2),
    .switch_event     (sw2),
    .failure_count    (fail2)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      tcnt++;
      if (period != 0 && tcnt % period == 0)
        monitored_toggle = ~monitored_toggle;
      if (period2 != 0 && tcnt % period2 == 0)
        mon2 = ~mon2;
    end
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_select", select, 1);
    check("rst_pgood", primary_good, 0);
    check("rst_switch", switch_event, 0);
    check("rst_fail", failure_count, 0);
    check("rst_sel2", sel2, 1);
    check("rst_fail2", fail2, 0);

    // Qualify with 16 toggles per window
    reset = 1'b0;
    cyc = 0;
    tcnt = 0;
    period = 4;
    tick(64);
    check("q_win1_sel", select, 1);
    tick(191);
    check("q_c255_sel", select, 1);
    check("q_c255_sw", switch_event, 0);
    tick(1);
    check("q_c256_sel", select, 0);
    check("q_c256_pg", primary_good, 1);
    check("q_c256_sw", switch_event, 1);

    // Monitored clock stops while in primary
    period = 0;
    tick(1);
    check("q_c257_sw", switch_event, 0);
    tick(62);
    check("stop_c319_sel", select, 0);
    tick(1);
    check("stop_c320_sel", select, 1);
    check("stop_c320_sw", switch_event, 1);
    check("stop_c320_pg", primary_good, 0);
    check("stop_c320_fail", failure_count, 1);
    tick(1);
    check("stop_c321_sw", switch_event, 0);

    // Too fast, then too slow: never qualifies
    period = 1;
    tick(256);
    check("fast_sel", select, 1);
    period = 16;
    tick(320);
    check("slow_sel", select, 1);
    check("slow_fail", failure_count, 1);

    // Three good, one bad, four good windows
    while (cyc % 64 != 0) tick(1);
    w0 = cyc;
    period = 4;
    tick(192);
    period = 0;
    tick(64);
    check("gap_w4_sel", select, 1);
    period = 4;
    tick(255);
    check("gap_w8end_sel", select, 1);
    tick(1);
    check("gap_after_sel", select, 0);
    check("gap_after_sw", switch_event, 1);

    // Force fallback for 10 cycles while primary
    tick(5);
    check("pre_force_sw", switch_event, 0);
    force_fallback = 1'b1;
    tick(1);
    check("force_sel", select, 1);
    check("force_sw", switch_event, 1);
    check("force_fail", failure_count, 1);
    tick(9);
    force_fallback = 1'b0;
    check("force_hold_sel", select, 1);
    check("force_hold_sw", switch_event, 0);
    tick(767 - (cyc - w0));
    check("requal_pre_sel", select, 1);
    tick(1);
    check("requal_sel", select, 0);
    check("requal_sw", switch_event, 1);

    // Asynchronous reset mid-window in primary
    tick(20);
    check("pre_rst_sel", select, 0);
    reset = 1'b1;
    #2;
    check("arst_sel", select, 1);
    check("arst_pg", primary_good, 0);
    check("arst_fail", failure_count, 0);
    check("arst_sw", switch_event, 0);
    tick(2);

    // Disable in fallback, re-enable starts a fresh window
    enable = 1'b0;
    reset = 1'b0;
    cyc = 0;
    tick(3);
    check("dis_fb_sw", switch_event, 0);
    check("dis_fb_sel", select, 1);
    enable = 1'b1;
    tick(255);
    check("reen_c258_sel", select, 1);
    tick(1);
    check("reen_c259_sel", select, 0);
    check("reen_c259_sw", switch_event, 1);
    enable = 1'b0;
    tick(1);
    check("dis_pr_sel", select, 1);
    check("dis_pr_sw", switch_event, 1);
    check("dis_pr_fail", failure_count, 0);
    tick(1);
    check("dis_pr_sw2", switch_event, 0);
    enable = 1'b1;
    period = 0;

    // Saturate the small instance's failure counter
    while (cyc % 16 != 0) tick(1);
    for (int i = 0; i < 256; i++) begin
      period2 = 4;
      tick(16);
      period2 = 0;
      tick(16);
      if (i == 0) check("sat_first", fail2, 1);
      if (i == 254) check("sat_255", fail2, 255);
    end
    check("sat_hold", fail2, 255);

    // Clear coincident with a loss
    period2 = 4;
    tick(16);
    period2 = 0;
    tick(15);
    check("clr_pre_sel2", sel2, 0);
    clr2 = 1'b1;
    tick(1);
    clr2 = 1'b0;
    check("clr_fail2", fail2, 0);
    check("clr_sel2", sel2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
